// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and sizing constants for the PWM driver
package pwm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
  localparam int CNT_MAX = 254;
  localparam int DUTY_W = 8;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: emits a tick every prescale+1 clocks while run is high
module pwm_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);
  logic [PRE_W-1:0] pre_cnt;
  // >= rather than == so lowering prescale below pre_cnt still ticks at once
  assign tick = run && (pre_cnt >= prescale);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre_cnt <= '0;
    else pre_cnt <= (!run || tick) ? '0 : pre_cnt + 1'b1;
endmodule

// File: rtl/pwm_driver.sv
// pwm_driver: glitch-free PWM with shadowed duty updates applied at period boundaries.
// Optional SLEW_LIMIT_EN limits each boundary's duty change to SLEW_STEP.
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int CNT_MAX = pwm_pkg::CNT_MAX,
  parameter int PRE_W = 8
`ifdef SLEW_LIMIT_EN
  , parameter int SLEW_STEP = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  input  logic              enable,
  input  logic [PRE_W-1:0]  prescale,
  output logic              pwm_out,
  output logic              period_end,
  output logic [DUTY_W-1:0] duty_active
);
  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(CNT_MAX);
  state_t state, state_nx;
  logic [DUTY_W-1:0] cnt, shadow, duty_next;
  logic pending, tick, run, boundary, xfer;
  assign run = state != IDLE;
  assign boundary = tick && cnt == LAST;
  assign duty_ready = !pending;
  assign xfer = duty_valid && !pending;
  pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk(clk), .rst_n(rst_n), .run(run), .prescale(prescale), .tick(tick)
  );
`ifdef SLEW_LIMIT_EN
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(SLEW_STEP);
  // stepping toward shadow never overshoots it, so no wrap past 0/255
  always_comb
    duty_next = (shadow > duty_active)
      ? ((shadow - duty_active > STEP) ? duty_active + STEP : shadow)
      : ((duty_active - shadow > STEP) ? duty_active - STEP : shadow);
`else
  assign duty_next = shadow;
`endif
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = enable ? RUN : IDLE;
      RUN:  state_nx = enable ? RUN : STOP;
      STOP: state_nx = enable ? RUN : (boundary ? IDLE : STOP);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      duty_active <= '0;
      pending <= 1'b0;
      pwm_out <= 1'b0;
      period_end <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= !run ? '0 : (tick ? ((cnt == LAST) ? '0 : cnt + 1'b1) : cnt);
      pwm_out <= run && (cnt < duty_active);
      period_end <= boundary;
      if (!run) begin
        if (xfer) duty_active <= duty_in;
        else if (pending) begin
          duty_active <= shadow;
          pending <= 1'b0;
        end
      end else if (xfer) begin
        shadow <= duty_in;
        pending <= 1'b1;
      end else if (boundary && pending) begin
        duty_active <= duty_next;
        pending <= duty_next != shadow;
      end
    end
endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver: directed self-checking bench for pwm_driver
module tb_pwm_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] duty_in = '0;
  logic duty_valid = 1'b0;
  logic duty_ready;
  logic enable = 1'b0;
  logic [7:0] prescale = '0;
  logic pwm_out, period_end;
  logic [7:0] duty_active;
  int checks = 0;
  int failures = 0;
  int n, highs, pes, bad, early;

  pwm_driver dut (
    .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .enable(enable), .prescale(prescale),
    .pwm_out(pwm_out), .period_end(period_end), .duty_active(duty_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    duty_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_duty(input logic [7:0] v);
    int k = 0;
    duty_in = v;
    duty_valid = 1'b1;
    while (!duty_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!duty_ready) check("send_timeout", duty_ready, 1);
    @(negedge clk);
    duty_valid = 1'b0;
  endtask

  task automatic wait_pe(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!period_end && cnt < budget);
    if (!period_end) check("pe_timeout", period_end, 1);
  endtask

  task automatic measure(input int len, output int hi, output int pe);
    hi = 0;
    pe = 0;
    repeat (len) begin
      @(negedge clk);
      hi += int'(pwm_out);
      pe += int'(period_end);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_pe", period_end, 0);
    check("rst_duty", duty_active, 0);
    check("rst_ready", duty_ready, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_pwm", pwm_out, 0);
    check("idle_pe", period_end, 0);
    check("idle_duty", duty_active, 0);
    check("idle_ready", duty_ready, 1);

    // duty 128 loaded in IDLE, then run at prescale 0
    send_duty(8'd128);
    check("idle_load", duty_active, 128);
    check("idle_load_ready", duty_ready, 1);
    enable = 1'b1;
    wait_pe(400, n);
    measure(255, highs, pes);
    check("d128_high", highs, 128);
    check("d128_pes", pes, 1);
    check("d128_pe_last", period_end, 1);

    // duty 0 for a full period, then 255 across boundaries
    send_duty(8'd0);
    wait_pe(300, n);
    check("d0_applied", duty_active, 0);
    send_duty(8'd255);
    measure(254, highs, pes);
    check("d0_high", highs, 0);
    check("d0_pe_last", period_end, 1);
    check("d255_applied", duty_active, 255);
    measure(510, highs, pes);
    check("d255_high", highs, 510);
    check("d255_pes", pes, 2);

    // mid-period update is held in shadow until the boundary
    send_duty(8'd128);
    wait_pe(300, n);
    check("d128_reapplied", duty_active, 128);
    repeat (50) @(negedge clk);
    duty_in = 8'd64;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    check("shadow_ready", duty_ready, 0);
    check("shadow_hold", duty_active, 128);
    duty_in = 8'd10;
    duty_valid = 1'b1;
    bad = 0;
    early = 0;
    n = 0;
    @(negedge clk);
    while (!period_end && n < 300) begin
      bad += int'(duty_active != 8'd128);
      early += int'(duty_ready);
      @(negedge clk);
      n++;
    end
    check("hold_until_pe", bad, 0);
    check("stall_ready", early, 0);
    check("pe_apply", duty_active, 64);
    check("pe_ready", duty_ready, 1);
    @(negedge clk);
    duty_valid = 1'b0;
    check("second_xfer", duty_ready, 0);
    check("second_hold", duty_active, 64);

    // prescale 3: 1020-clk period, 512 high
    do_reset();
    prescale = 8'd3;
    send_duty(8'd128);
    enable = 1'b1;
    wait_pe(1200, n);
    measure(1020, highs, pes);
    check("pre3_high", highs, 512);
    check("pre3_pes", pes, 1);
    check("pre3_pe_last", period_end, 1);

    // graceful stop at cnt=100 finishes the period
    prescale = 8'd0;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    wait_pe(400, n);
    check("stop_len", n, 155);
    measure(20, highs, pes);
    check("stop_idle_high", highs, 0);
    check("stop_idle_pes", pes, 0);

    // asynchronous reset mid-period
    enable = 1'b1;
    repeat (101) @(negedge clk);
    check("pre_rst_pwm", pwm_out, 1);
    rst_n = 1'b0;
    #1;
    check("arst_pwm", pwm_out, 0);
    check("arst_duty", duty_active, 0);
    check("arst_ready", duty_ready, 1);
    check("arst_pe", period_end, 0);

`ifdef SLEW_LIMIT_EN
    do_reset();
    prescale = 8'd0;
    enable = 1'b1;
    @(negedge clk);
    send_duty(8'd200);
    for (int i = 1; i <= 13; i++) begin
      wait_pe(300, n);
      check($sformatf("slew_%0d", i), duty_active, (16 * i > 200) ? 200 : 16 * i);
      check($sformatf("slew_ready_%0d", i), duty_ready, (i == 13) ? 1 : 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
